// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
//   Shared constants for the seven-segment scan reader.
//   - SEG_* : active-low segment patterns, written a..g left to right, so that
//             a literal assigned to a logic [0:6] bus lands a in bit 0.
//   - ST_*  : FSM state encodings for the frame assembler.
// -----------------------------------------------------------------------------
package sevenseg_pkg;

  localparam logic [0:6] SEG_BLANK = 7'b111_1111;
  localparam logic [0:6] SEG_0     = 7'b000_0001;
  localparam logic [0:6] SEG_1     = 7'b100_1111;
  localparam logic [0:6] SEG_2     = 7'b001_0010;
  localparam logic [0:6] SEG_3     = 7'b000_0110;
  localparam logic [0:6] SEG_4     = 7'b100_1100;
  localparam logic [0:6] SEG_5     = 7'b010_0100;
  localparam logic [0:6] SEG_6     = 7'b010_0000;
  localparam logic [0:6] SEG_7     = 7'b000_1111;
  localparam logic [0:6] SEG_8     = 7'b000_0000;
  localparam logic [0:6] SEG_9     = 7'b000_0100;
  localparam logic [0:6] SEG_A     = 7'b000_1000;
  localparam logic [0:6] SEG_B     = 7'b110_0000;
  localparam logic [0:6] SEG_C     = 7'b011_0001;
  localparam logic [0:6] SEG_D     = 7'b100_0010;
  localparam logic [0:6] SEG_E     = 7'b011_0000;
  localparam logic [0:6] SEG_F     = 7'b011_1000;

  // Frame assembler states.
  localparam logic [0:0] ST_IDLE   = 1'b0;  // collecting digits
  localparam logic [0:0] ST_COMMIT = 1'b1;  // one-cycle hand-off of a full frame

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// -----------------------------------------------------------------------------
// sevenseg_pattern_decode
//   Combinational lookup from an active-low segment pattern to a BCD nibble.
//   Optional macro SEVENSEG_READER_HEX_EN adds the hex letters A..F.
// Ports:
//   seg   in  [0:6] segments a..g, active-low (seg[0] = a)
//   hit   out 1     pattern is a known code (digit or blank)
//   blank out 1     pattern is the all-off pattern (code reported as 0)
//   code  out 4     decoded value
// -----------------------------------------------------------------------------
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [0:6] seg,
  output logic       hit,
  output logic       blank,
  output logic [3:0] code
);

  always_comb begin
    hit   = 1'b1;
    blank = 1'b0;
    code  = 4'd0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: blank = 1'b1;
`ifdef SEVENSEG_READER_HEX_EN
      SEG_A:     code = 4'hA;
      SEG_B:     code = 4'hB;
      SEG_C:     code = 4'hC;
      SEG_D:     code = 4'hD;
      SEG_E:     code = 4'hE;
      SEG_F:     code = 4'hF;
`endif
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_reader.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_reader
//   Monitors a multiplexed, active-low seven-segment bus and recovers the BCD
//   value of each digit, assembling NDIG digits into a frame.
//   Optional macro SEVENSEG_READER_HEX_EN: also decode hex letters A..F.
// Parameters:
//   NDIG   number of multiplexed digits (2..8)
//   STABLE consecutive identical samples needed to accept a digit (>=2)
//   CNT_W  stability counter width, must hold STABLE
// Ports:
//   clk          in  1        clock, rising edge
//   reset_n      in  1        asynchronous active-low reset
//   seg          in  [0:6]    segments a..g, active-low
//   an           in  NDIG     digit enables, active-low, one low when valid
//   frame_bcd    out 4*NDIG   digit i in [4i+3:4i]
//   frame_blank  out NDIG     digit i was blank
//   frame_valid  out 1        frame available
//   frame_ready  in  1        consumer ready
//   dec_err      out 1        sticky: an accepted pattern matched no code
//   overrun      out 1        sticky: frame completed while previous still held
//   dbg_state    out 1        current FSM state (ST_IDLE / ST_COMMIT)
//
// Handshake: a frame transfers on a cycle where frame_valid && frame_ready;
// frame_valid falls on the next edge. frame_bcd/frame_blank never change while
// frame_valid is high; a frame completing in that window is dropped (overrun).
// -----------------------------------------------------------------------------
module sevenseg_scan_reader
  import sevenseg_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [0:6]        seg,
  input  logic [NDIG-1:0]   an,
  output logic [4*NDIG-1:0] frame_bcd,
  output logic [NDIG-1:0]   frame_blank,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              dec_err,
  output logic              overrun,
  output logic [0:0]        dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE - 2);

  // Input stage and the previous sample for the stability compare.
  logic [NDIG-1:0] an_q,  an_prev_q;
  logic [0:6]      seg_q, seg_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q       <= '0;
      seg_q      <= '0;
      an_prev_q  <= '0;
      seg_prev_q <= '0;
    end else begin
      an_q       <= an;
      seg_q      <= seg;
      an_prev_q  <= an_q;
      seg_prev_q <= seg_q;
    end
  end

  // act is the one-hot digit mask of the current sample.
  logic [NDIG-1:0] act;
  logic            sample_ok;
  logic            same;

  assign act       = ~an_q;
  assign sample_ok = (act != '0) && ((act & (act - 1'b1)) == '0);
  assign same      = (an_q == an_prev_q) && (seg_q == seg_prev_q);

  // Stability counter: saturates at STABLE-1 so accept fires exactly once.
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  assign accept = sample_ok && same && (cnt_q == CNT_PRE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!sample_ok || !same) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  logic       dec_hit;
  logic       dec_blank;
  logic [3:0] dec_code;

  sevenseg_pattern_decode u_decode (
    .seg   (seg_q),
    .hit   (dec_hit),
    .blank (dec_blank),
    .code  (dec_code)
  );

  // Digits written into the shadow frame this cycle (one-hot or zero).
  logic [NDIG-1:0] seen_set;
  assign seen_set = (accept && dec_hit) ? act : '0;

  logic [4*NDIG-1:0] shadow_bcd_q;
  logic [NDIG-1:0]   shadow_blank_q;
  logic [NDIG-1:0]   seen_q;
  logic [0:0]        state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_bcd_q   <= '0;
      shadow_blank_q <= '0;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (seen_set[i]) begin
          shadow_bcd_q[4*i +: 4] <= dec_code;
          shadow_blank_q[i]      <= dec_blank;
        end
      end
    end
  end

  // An accept landing in the COMMIT cycle belongs to the next frame, so it
  // survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen_q <= '0;
    end else if (state_q == ST_COMMIT) begin
      seen_q <= seen_set;
    end else begin
      seen_q <= seen_q | seen_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (&seen_q) state_q <= ST_COMMIT;
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_bcd   <= '0;
      frame_blank <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (state_q == ST_COMMIT) begin
        if (!frame_valid) begin
          frame_bcd   <= shadow_bcd_q;
          frame_blank <= shadow_blank_q;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_err <= 1'b0;
    end else if (accept && !dec_hit) begin
      dec_err <= 1'b1;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
module tb_sevenseg_scan_reader;

  localparam logic [0:6] P_BLANK = 7'b111_1111;
  localparam logic [0:6] P0 = 7'b000_0001;
  localparam logic [0:6] P1 = 7'b100_1111;
  localparam logic [0:6] P2 = 7'b001_0010;
  localparam logic [0:6] P3 = 7'b000_0110;
  localparam logic [0:6] P4 = 7'b100_1100;
  localparam logic [0:6] P5 = 7'b010_0100;
  localparam logic [0:6] P6 = 7'b010_0000;
  localparam logic [0:6] P7 = 7'b000_1111;
  localparam logic [0:6] P8 = 7'b000_0000;
  localparam logic [0:6] P9 = 7'b000_0100;
  localparam logic [0:6] PA = 7'b000_1000;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset_n;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_blank;
  logic        frame_valid;
  logic        frame_ready;
  logic        dec_err;
  logic        overrun;
  logic [0:0]  dbg_state;

  always #5 clk = ~clk;

  sevenseg_scan_reader #(.NDIG(4), .STABLE(8), .CNT_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg         (seg),
    .an          (an),
    .frame_bcd   (frame_bcd),
    .frame_blank (frame_blank),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .dec_err     (dec_err),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // scoreboard: {blank[3:0], bcd[15:0]}
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: compares every transferred frame against the queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && frame_valid === 1'b1 && frame_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'({frame_blank, frame_bcd}), 32'hFFFFFFFF);
      end else begin
        check("frame", 32'({frame_blank, frame_bcd}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks: called and return just after a rising edge
  task automatic scan(input int idx, input logic [0:6] pat, input int cycles);
    logic [3:0] one;
    one = 4'b0001 << idx;
    an  = ~one;
    seg = pat;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int cycles);
    an  = 4'hF;
    seg = P_BLANK;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_no_frame(input string tag, input int cycles);
    bit got;
    got = 1'b0;
    an  = 4'hF;
    seg = P_BLANK;
    repeat (cycles) begin
      @(negedge clk);
      if (frame_valid) got = 1'b1;
    end
    @(posedge clk);
    #1;
    check(tag, 32'(got), 32'd0);
  endtask

  // Returns at the falling edge where frame_valid was first seen.
  task automatic wait_frame(input string tag, input int budget);
    int k;
    k   = 0;
    an  = 4'hF;
    seg = P_BLANK;
    @(negedge clk);
    while (!frame_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(frame_valid), 32'd1);
  endtask

  task automatic valid_drops(input string tag);
    @(negedge clk);
    check(tag, 32'(frame_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    reset_n     = 1'b0;
    frame_ready = 1'b1;
    an          = 4'hF;
    seg         = P_BLANK;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd",     32'(frame_bcd),   32'd0);
    check("rst_blank",   32'(frame_blank), 32'd0);
    check("rst_valid",   32'(frame_valid), 32'd0);
    check("rst_dec_err", 32'(dec_err),     32'd0);
    check("rst_overrun", 32'(overrun),     32'd0);
    check("rst_state",   32'(dbg_state),   32'd0);
    reset_n = 1'b1;
    idle(2);

    // reset mid-collection discards digits 0 and 1
    scan(0, P5, 8);
    scan(1, P6, 8);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", 32'(frame_valid), 32'd0);
    check("midrst_bcd",   32'(frame_bcd),   32'd0);
    check("midrst_state", 32'(dbg_state),   32'd0);
    reset_n = 1'b1;
    idle(2);
    scan(2, P3, 8);
    scan(3, P4, 8);
    expect_no_frame("midrst_partial", 30);

    // digits 1,2,3,4 -> 16'h4321
    exp_q.push_back({4'b0000, 16'h4321});
    scan(0, P1, 8);
    scan(1, P2, 8);
    wait_frame("f4321_valid", 20);
    valid_drops("f4321_one_cycle");
    check("f4321_dec_err", 32'(dec_err), 32'd0);

    // digit 2 held only 6 cycles; digit 3 blank
    scan(0, P7, 8);
    scan(1, P8, 8);
    scan(2, P9, 6);
    scan(3, P_BLANK, 8);
    expect_no_frame("short_hold", 30);
    exp_q.push_back({4'b1000, 16'h0987});
    scan(2, P9, 8);
    wait_frame("f0987_valid", 20);
    valid_drops("f0987_one_cycle");

    // two enables low: must not accept
    an  = 4'b1100;
    seg = P1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    scan(1, P6, 8);
    scan(2, P5, 8);
    scan(3, P0, 8);
    expect_no_frame("two_low", 30);
    exp_q.push_back({4'b0000, 16'h0568});
    scan(0, P8, 8);
    wait_frame("f0568_valid", 20);
    valid_drops("f0568_one_cycle");
    check("pre_hex_dec_err", 32'(dec_err), 32'd0);

    // hex letter A on digit 0
`ifdef SEVENSEG_READER_HEX_EN
    exp_q.push_back({4'b0000, 16'h321A});
    scan(0, PA, 8);
    scan(1, P1, 8);
    scan(2, P2, 8);
    scan(3, P3, 8);
    wait_frame("f321a_valid", 20);
    valid_drops("f321a_one_cycle");
    check("hex_dec_err", 32'(dec_err), 32'd0);
`else
    scan(0, PA, 8);
    scan(1, P1, 8);
    scan(2, P2, 8);
    scan(3, P3, 8);
    expect_no_frame("hex_not_accepted", 30);
    check("hex_dec_err", 32'(dec_err), 32'd1);
    exp_q.push_back({4'b0000, 16'h3214});
    scan(0, P4, 8);
    wait_frame("f3214_valid", 20);
    valid_drops("f3214_one_cycle");
`endif

    // overrun: consumer stalls across two frames
    check("pre_overrun", 32'(overrun), 32'd0);
    frame_ready = 1'b0;
    exp_q.push_back({4'b0000, 16'h6789});
    scan(0, P9, 8);
    scan(1, P8, 8);
    scan(2, P7, 8);
    scan(3, P6, 8);
    wait_frame("f6789_valid", 20);
    @(posedge clk);
    #1;
    scan(0, P1, 8);
    scan(1, P1, 8);
    scan(2, P1, 8);
    scan(3, P1, 8);
    idle(10);
    check("overrun_flag",  32'(overrun),     32'd1);
    check("overrun_valid", 32'(frame_valid), 32'd1);
    check("overrun_bcd",   32'(frame_bcd),   32'h6789);
    frame_ready = 1'b1;
    @(negedge clk);
    valid_drops("overrun_release");
    check("overrun_sticky", 32'(overrun), 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    tests_failed++;
    $error("FAIL timeout: observed no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
